// File: rtl/ram_write_arbiter.sv
// ram_write_arbiter: round-robin arbiter for the ping-pong buffer write port.
// Each grant lasts one full burst, or ends early when the owner stops driving valid for TIMEOUT cycles.
module ram_write_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int BURST   = 16,
  parameter int TIMEOUT = 64,
  parameter int GNT_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = $clog2(BURST + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic signed [WIDTH-1:0]   buf_data_o,
  output logic                      buf_valid_o,
  input  logic                      buf_ready_i,
  output logic                      grant_valid_o,
  output logic [GNT_W-1:0]          grant_id_o,
  output logic [CNT_W-1:0]          burst_count_o,
  output logic                      timeout_o
);
  localparam int IDLE_W = $clog2(TIMEOUT);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_n;
  logic [GNT_W-1:0]  rr_ptr, rr_n, gid_n, winner, lo_any, lo_hi, next_ptr;
  logic [CNT_W-1:0]  cnt_n;
  logic [IDLE_W-1:0] idle_cnt, idle_n;
  logic              hi_found, sel_valid, accept, granted, to_n;

  assign granted       = state == GRANT;
  assign grant_valid_o = granted;

  // Lowest valid index at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    lo_any      = '0;
    lo_hi       = '0;
    hi_found    = 1'b0;
    sel_valid   = 1'b0;
    buf_data_o  = '0;
    req_ready_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) lo_any = GNT_W'(k);
      if (req_valid_i[k] && GNT_W'(k) >= rr_ptr) begin
        lo_hi    = GNT_W'(k);
        hi_found = 1'b1;
      end
      if (granted && grant_id_o == GNT_W'(k)) begin
        sel_valid      = req_valid_i[k];
        buf_data_o     = req_data_i[k*WIDTH +: WIDTH];
        req_ready_o[k] = buf_ready_i;
      end
    end
  end

  assign winner      = hi_found ? lo_hi : lo_any;
  assign buf_valid_o = sel_valid;
  assign accept      = sel_valid && buf_ready_i;
  assign next_ptr    = grant_id_o == GNT_W'(NUM_REQ - 1) ? '0 : grant_id_o + 1'b1;

  // An accept always beats an expiring idle counter, so valid is never withdrawn unaccepted.
  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    gid_n   = grant_id_o;
    cnt_n   = burst_count_o;
    idle_n  = idle_cnt;
    to_n    = 1'b0;
    if (flush_i) begin
      state_n = IDLE;
      rr_n    = '0;
      cnt_n   = '0;
      idle_n  = '0;
    end else if (!granted) begin
      if (|req_valid_i) begin
        state_n = GRANT;
        gid_n   = winner;
        cnt_n   = '0;
        idle_n  = '0;
      end
    end else if (accept) begin
      idle_n = '0;
      cnt_n  = burst_count_o + 1'b1;
      if (burst_count_o == CNT_W'(BURST - 1)) begin
        state_n = IDLE;
        rr_n    = next_ptr;
        cnt_n   = '0;
      end
    end else if (!sel_valid) begin
      idle_n = idle_cnt + 1'b1;
      if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
        state_n = IDLE;
        rr_n    = next_ptr;
        cnt_n   = '0;
        idle_n  = '0;
        to_n    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_id_o    <= '0;
      burst_count_o <= '0;
      idle_cnt      <= '0;
      timeout_o     <= 1'b0;
    end else begin
      state         <= state_n;
      rr_ptr        <= rr_n;
      grant_id_o    <= gid_n;
      burst_count_o <= cnt_n;
      idle_cnt      <= idle_n;
      timeout_o     <= to_n;
    end
  end
endmodule
